// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register. Holds the PC, issues
//   word fetches to instruction memory and registers the returned word with
//   its PC+4. The opcode field of the registered word is exported directly to
//   the decode-stage control unit.
//
// Ports
//   clk_sys        in   rising-edge clock
//   reset          in   synchronous, active-high
//   imem_addr      out  fetch address (current pc)
//   imem_req       out  fetch request (combinational)
//   imem_rdata     in   instruction word, valid with imem_ready
//   imem_ready     in   memory returns data this cycle
//   stall          in   hold PC and IF/ID (load-use hazard)
//   branch_taken   in   redirect to branch_target and flush IF/ID
//   branch_target  in   redirect address (low two bits ignored)
//   if_id_instr    out  registered instruction (0 for a bubble)
//   if_id_pc4      out  registered PC+4 of if_id_instr
//   if_id_valid    out  if_id_instr is a real instruction
//   instr_op       out  if_id_instr[31:26]
//   fetch_count    out  number of instructions accepted into IF/ID
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | first cycle after reset; no fetch issued, IF/ID holds reset
// RUN   | normal fetch; left only by reset
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk_sys,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [5:0]  instr_op,
   output logic [31:0] fetch_count
);

   typedef enum logic {BOOT, RUN} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   // Wraps modulo 2^32, so the last word of the address space fetches
   // into address zero.
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign imem_req  = (state == RUN) && !stall && !branch_taken;
   assign instr_op  = if_id_instr[31:26];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= PC_RESET;
         if_id_instr <= 32'd0;
         if_id_pc4   <= 32'd0;
         if_id_valid <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         state <= RUN;
         if (branch_taken) begin
            // Flush: the word in IF/ID is on the wrong path. pc4 is left
            // alone because a bubble's pc4 is never consumed.
            pc          <= {branch_target[31:2], 2'b00};
            if_id_instr <= 32'd0;
            if_id_valid <= 1'b0;
         end else if (stall) begin
            // Everything holds; any returned data is dropped and re-fetched.
         end else if (state == RUN) begin
            if (imem_ready) begin
               pc          <= pc_plus4;
               if_id_instr <= imem_rdata;
               if_id_pc4   <= pc_plus4;
               if_id_valid <= 1'b1;
               fetch_count <= fetch_count + 32'd1;
            end else begin
               // Memory wait: bubble downstream, repeat the same address.
               if_id_instr <= 32'd0;
               if_id_valid <= 1'b0;
            end
         end
      end
   end

endmodule
